// File: rtl/aes_pkg.sv
// Shared types and constants for the AES SPI link: FSM state type,
// block width and the set of supported key widths.
package aes_pkg;

   localparam int BLK_W = 128;

   localparam int K_128 = 128;
   localparam int K_192 = 192;
   localparam int K_256 = 256;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SHIFT_IN  = 3'd1,
      ST_LAUNCH    = 3'd2,
      ST_WAIT      = 3'd3,
      ST_SHIFT_OUT = 3'd4
   } state_e;

   // True only for the AES key sizes the link can carry.
   function automatic bit key_w_legal(input int k);
      return (k == K_128) || (k == K_192) || (k == K_256);
   endfunction

endpackage

// File: rtl/aes_sync_edge.sv
// SYNC-deep synchroniser for an asynchronous input, with single-cycle
// rise/fall pulses generated from the synchronised level.
module aes_sync_edge #(
   parameter int SYNC = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [SYNC-1:0] sync_q;
   logic            prev_q;

   // Synchroniser chain plus one history flop for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC-2:0], d};
         prev_q <= sync_q[SYNC-1];
      end
   end

   assign rise =  sync_q[SYNC-1] & ~prev_q;
   assign fall = ~sync_q[SYNC-1] &  prev_q;

endmodule

// File: rtl/aes_spi_link.sv
// SPI front end for an AES core: shifts in a {block, key} frame while
// load is high, launches the core, then shifts the result back out on
// sdo. Optional macro AES_SPI_KEY_RETAIN_EN also accepts 128-bit frames
// that replace only the block and reuse the last loaded key.
module aes_spi_link
   import aes_pkg::*;
#(
   parameter int K    = 128,
   parameter int SYNC = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sck,
   input  logic             sdi,
   input  logic             load,
   output logic             sdo,
   output logic             done,
   output logic             err,
   output logic             start,
   output logic [BLK_W-1:0] blk_out,
   output logic [K-1:0]     key_out,
   input  logic             core_done,
   input  logic [BLK_W-1:0] core_result
);

   localparam int FW = BLK_W + K;
   localparam int CW = $clog2(FW + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(FW);
   localparam logic [CW-1:0] CNT_SAT  = CW'(FW + 1);
`ifdef AES_SPI_KEY_RETAIN_EN
   localparam logic [CW-1:0] CNT_BLK  = CW'(BLK_W);
`endif

   if (!key_w_legal(K)) begin : g_bad_k
      $error("aes_spi_link: K must be 128, 192 or 256");
   end
   if (SYNC < 2) begin : g_bad_sync
      $error("aes_spi_link: SYNC must be at least 2");
   end

   state_e           state;
   logic [CW-1:0]    cnt;
   logic [FW-1:0]    frame;
   logic [BLK_W-1:0] res_q;
   logic [SYNC-1:0]  sdi_sync;
   logic             sdi_s;
   logic             sck_rise, sck_fall;
   logic             load_rise, load_fall;
`ifdef AES_SPI_KEY_RETAIN_EN
   logic             key_vld;
`endif

   aes_sync_edge #(.SYNC(SYNC)) u_sck_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sck),
      .rise  (sck_rise),
      .fall  (sck_fall)
   );

   aes_sync_edge #(.SYNC(SYNC)) u_load_sync (
      .clk   (clk),
      .reset (reset),
      .d     (load),
      .rise  (load_rise),
      .fall  (load_fall)
   );

   // sdi uses the same depth as sck so the sampled bit lines up with the sck rise pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sdi_sync <= '0;
      else        sdi_sync <= {sdi_sync[SYNC-2:0], sdi};
   end

   assign sdi_s = sdi_sync[SYNC-1];

   // Frame shift register; only the bit counter decides whether its contents are used.
   always_ff @(posedge clk) begin
      if (state == ST_SHIFT_IN && sck_rise) frame <= {frame[FW-2:0], sdi_s};
   end

   // Link FSM: frame capture, core launch, result capture and shift-out.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         err     <= 1'b0;
         done    <= 1'b0;
         start   <= 1'b0;
         blk_out <= '0;
         key_out <= '0;
         res_q   <= '0;
`ifdef AES_SPI_KEY_RETAIN_EN
         key_vld <= 1'b0;
`endif
      end else begin
         start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load_rise) begin
                  cnt   <= '0;
                  err   <= 1'b0;
                  state <= ST_SHIFT_IN;
               end
            end
            ST_SHIFT_IN: begin
               if (sck_rise && cnt != CNT_SAT) cnt <= cnt + 1'b1;
               if (load_fall) begin
                  if (cnt == CNT_FULL) begin
                     blk_out <= frame[FW-1:K];
                     key_out <= frame[K-1:0];
                     start   <= 1'b1;
                     state   <= ST_LAUNCH;
`ifdef AES_SPI_KEY_RETAIN_EN
                     key_vld <= 1'b1;
                  end else if (cnt == CNT_BLK && key_vld) begin
                     blk_out <= frame[BLK_W-1:0];
                     start   <= 1'b1;
                     state   <= ST_LAUNCH;
`endif
                  end else begin
                     err   <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
            end
            ST_LAUNCH: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (load_rise) err <= 1'b1;
               if (core_done) begin
                  res_q <= core_result;
                  done  <= 1'b1;
                  state <= ST_SHIFT_OUT;
               end
            end
            ST_SHIFT_OUT: begin
               if (load_rise) begin
                  done  <= 1'b0;
                  res_q <= '0;
                  cnt   <= '0;
                  state <= ST_SHIFT_IN;
               end else if (sck_fall) begin
                  res_q <= {res_q[BLK_W-2:0], 1'b0};
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign sdo = res_q[BLK_W-1];

endmodule
